// File: rtl/rgb_strip_driver.sv
// Single-wire RGB/RGBW LED chain driver: streams a frame of pixels as PWM-encoded
// bits, MSB first, through a one-entry holding register, then holds the line low to latch.
module rgb_strip_driver #(
    parameter int BITS_PER_LED = 24,
    parameter int CNT_W        = 16,
    parameter int LED_CNT_W    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    start,
    input  logic [LED_CNT_W-1:0]    led_count,
    input  logic [CNT_W-1:0]        t_period,
    input  logic [CNT_W-1:0]        t_hi1,
    input  logic [CNT_W-1:0]        t_hi0,
    input  logic [CNT_W-1:0]        t_latch,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    output logic                    outpin
);

    localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_LED - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, LATCH} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [CNT_W-1:0]        hi1_q, hi1_d;
    logic [CNT_W-1:0]        hi0_q, hi0_d;
    logic [CNT_W-1:0]        latch_len_q, latch_len_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LED_CNT_W-1:0]    led_count_q, led_count_d;
    logic [LED_CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LED_CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [BITS_PER_LED-1:0] hold_q, hold_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
    logic                    hold_full_q, hold_full_d;
    logic                    abort_q, abort_d;
    logic                    outpin_q, outpin_d;
    logic                    done_q, done_d;
    logic                    underrun_q, underrun_d;

    logic                    stop_req, bit_end, pix_end, frame_end, drain, accept;
    logic [LED_CNT_W-1:0]    pix_next;

    assign busy      = (state_q != IDLE);
    assign stop_req  = abort_q | ~en;
    assign bit_end   = (state_q == SEND) && (cnt_q == period_q - CNT_W'(1));
    assign pix_end   = bit_end && (bit_idx_q == LAST_BIT);
    assign pix_next  = pix_cnt_q + LED_CNT_W'(1);
    assign frame_end = pix_end && (pix_next == led_count_q);
    assign drain     = hold_full_q &&
                       (((state_q == WAIT_FIRST) && !stop_req) ||
                        (pix_end && !frame_end && !stop_req));

    // Stream handshake: a word transfers on any cycle where pix_valid && pix_ready;
    // pix_ready never depends on pix_valid, and a drain on that cycle frees the slot first.
    assign pix_ready = (~hold_full_q | drain) & busy & (acc_cnt_q < led_count_q) &
                       (state_q != LATCH);
    assign accept    = pix_valid & pix_ready;

    assign done      = done_q;
    assign underrun  = underrun_q;
    assign outpin    = outpin_q;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        hi1_d       = hi1_q;
        hi0_d       = hi0_q;
        latch_len_d = latch_len_q;
        cnt_d       = cnt_q;
        led_count_d = led_count_q;
        pix_cnt_d   = pix_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = busy ? (abort_q | ~en) : 1'b0;

        if (drain) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = pix_data;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + LED_CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                // The cycle done pulses still counts as the tail of the previous frame.
                if (start && en && !done_q) begin
                    period_d    = (t_period < CNT_W'(2)) ? CNT_W'(2) : t_period;
                    hi1_d       = t_hi1;
                    hi0_d       = t_hi0;
                    latch_len_d = (t_latch == '0) ? CNT_W'(1) : t_latch;
                    led_count_d = led_count;
                    pix_cnt_d   = '0;
                    acc_cnt_d   = '0;
                    cnt_d       = '0;
                    bit_idx_d   = '0;
                    hold_full_d = 1'b0;
                    state_d     = (led_count == '0) ? LATCH : WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (stop_req) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else if (hold_full_q) begin
                    shift_d   = hold_q;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = shift_q << 1;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (pix_end) begin
                        bit_idx_d = '0;
                        pix_cnt_d = pix_next;
                        if (frame_end || stop_req) begin
                            state_d = LATCH;
                        end else if (hold_full_q) begin
                            shift_d = hold_q;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = LATCH;
                        end
                    end else if (stop_req) begin
                        state_d = LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                hold_full_d = 1'b0;
                if (cnt_q == latch_len_q - CNT_W'(1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Level for the counter value being loaded; it shows on outpin for that cycle.
        outpin_d = (state_d == SEND) &&
                   (cnt_d < (shift_d[BITS_PER_LED-1] ? hi1_q : hi0_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            period_q    <= '0;
            hi1_q       <= '0;
            hi0_q       <= '0;
            latch_len_q <= '0;
            cnt_q       <= '0;
            led_count_q <= '0;
            pix_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            hold_full_q <= 1'b0;
            abort_q     <= 1'b0;
            outpin_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            hi1_q       <= hi1_d;
            hi0_q       <= hi0_d;
            latch_len_q <= latch_len_d;
            cnt_q       <= cnt_d;
            led_count_q <= led_count_d;
            pix_cnt_q   <= pix_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            hold_full_q <= hold_full_d;
            abort_q     <= abort_d;
            outpin_q    <= outpin_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_rgb_strip_driver.sv
// Directed bench for rgb_strip_driver: 24-bit and 32-bit instances share stimulus,
// and each frame's line waveform is compared cycle by cycle with an expected queue.
module tb_rgb_strip_driver;

    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        reset, en, start, pix_valid, sel;
    logic [9:0]  led_count;
    logic [15:0] t_period, t_hi1, t_hi0, t_latch;
    logic [31:0] pix_data32;

    logic start24, ready24, busy24, done24, und24, out24;
    logic start32, ready32, busy32, done32, und32, out32;
    logic o_ready, o_busy, o_done, o_und, o_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pix_mem [8];
    logic [0:0]  wave_q [$];
    logic [0:0]  exp_q [$];
    int          last_first_hi, last_done_at;

    assign start24 = start & ~sel;
    assign start32 = start & sel;
    assign o_ready = sel ? ready32 : ready24;
    assign o_busy  = sel ? busy32  : busy24;
    assign o_done  = sel ? done32  : done24;
    assign o_und   = sel ? und32   : und24;
    assign o_out   = sel ? out32   : out24;

    always #5 clk = ~clk;

    rgb_strip_driver #(.BITS_PER_LED(24), .CNT_W(16), .LED_CNT_W(10)) dut24 (
        .clk(clk), .reset(reset), .en(en), .start(start24), .led_count(led_count),
        .t_period(t_period), .t_hi1(t_hi1), .t_hi0(t_hi0), .t_latch(t_latch),
        .pix_data(pix_data32[23:0]), .pix_valid(pix_valid), .pix_ready(ready24),
        .busy(busy24), .done(done24), .underrun(und24), .outpin(out24)
    );

    rgb_strip_driver #(.BITS_PER_LED(32), .CNT_W(16), .LED_CNT_W(10)) dut32 (
        .clk(clk), .reset(reset), .en(en), .start(start32), .led_count(led_count),
        .t_period(t_period), .t_hi1(t_hi1), .t_hi0(t_hi0), .t_latch(t_latch),
        .pix_data(pix_data32), .pix_valid(pix_valid), .pix_ready(ready32),
        .busy(busy32), .done(done32), .underrun(und32), .outpin(out32)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string tag, input int bits, input int n_led, input int n_sup,
                             input bit keep_valid, input int per, input int hi1, input int hi0,
                             input int lat, input int drop_en_at, input bit poke_start,
                             input bit start_on_done, input int exp_bits, input int exp_und,
                             input int exp_acc);
        int idx, first_hi, done_at, und_at, n_und, accepted, ready_late;
        int p_eff, l_eff, ws, n_bad, busy_after, rel, b, k, h;
        logic [31:0] word;
        logic e;
        bit take;
        p_eff = (per < 2) ? 2 : per;
        l_eff = (lat < 1) ? 1 : lat;
        wave_q.delete();
        exp_q.delete();
        idx = 0; first_hi = -1; done_at = -1; und_at = -1;
        n_und = 0; accepted = 0; ready_late = 0;
        led_count  = 10'(n_led);
        t_period   = 16'(per);
        t_hi1      = 16'(hi1);
        t_hi0      = 16'(hi0);
        t_latch    = 16'(lat);
        pix_data32 = (n_sup > 0) ? pix_mem[0] : '1;
        pix_valid  = (n_sup > 0) || keep_valid;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_at < 0 && idx < LIMIT) begin
            @(negedge clk);
            wave_q.push_back(o_out);
            if (o_out && first_hi < 0) first_hi = idx;
            if (o_und) begin n_und++; und_at = idx; end
            if (o_ready && accepted >= n_led) ready_late++;
            if (o_done) begin
                done_at = idx;
                if (start_on_done) start = 1'b1;
            end
            take = pix_valid && o_ready;
            @(posedge clk); #1;
            start = poke_start && (idx == 100);
            if (take) begin
                accepted++;
                pix_data32 = (accepted < n_sup) ? pix_mem[accepted] : '1;
                pix_valid  = (accepted < n_sup) || keep_valid;
            end
            if (drop_en_at >= 0 && first_hi >= 0 && idx - first_hi == drop_en_at) en = 1'b0;
            idx++;
        end
        pix_valid = 1'b0;
        check_eq({tag, ":done_seen"}, 32'(done_at >= 0), 32'd1);
        if (done_at >= 0) begin
            ws = done_at - l_eff - exp_bits * p_eff;
            check_eq({tag, ":win_start"}, 32'(ws >= 0), 32'd1);
            for (int j = 0; j <= done_at; j++) begin
                e = 1'b0;
                if (j >= ws && j < ws + exp_bits * p_eff) begin
                    rel  = j - ws;
                    b    = rel / p_eff;
                    k    = rel % p_eff;
                    word = pix_mem[b / bits];
                    h    = word[bits - 1 - (b % bits)] ? hi1 : hi0;
                    e    = (k < h);
                end
                exp_q.push_back(e);
            end
            n_bad = 0;
            while (exp_q.size() > 0) begin
                if (wave_q.pop_front() !== exp_q.pop_front()) n_bad++;
            end
            check_eq({tag, ":wave_bad_cycles"}, n_bad, 0);
            if (exp_und > 0) check_eq({tag, ":underrun_at"}, und_at, done_at - l_eff);
        end
        check_eq({tag, ":underrun_cnt"}, n_und, exp_und);
        check_eq({tag, ":accepted"}, accepted, exp_acc);
        check_eq({tag, ":ready_after_last"}, ready_late, 0);
        last_first_hi = first_hi;
        last_done_at  = done_at;
        busy_after = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_busy || o_done) busy_after++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq({tag, ":idle_after"}, busy_after, 0);
        en = 1'b1;
    endtask

    initial begin
        bit found;
        int n_done;
        sel = 1'b0; reset = 1'b1; en = 1'b1; start = 1'b0; pix_valid = 1'b0;
        led_count = '0; t_period = '0; t_hi1 = '0; t_hi0 = '0; t_latch = '0; pix_data32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset:out24", 32'({out24, busy24, done24, und24, ready24}), 32'd0);
        check_eq("reset:out32", 32'({out32, busy32, done32, und32, ready32}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        pix_mem[0] = 32'h00A50F00;
        run_frame("t1_single", 24, 1, 1, 0, 10, 7, 3, 50, -1, 0, 1, 24, 0, 1);
        check_eq("t1_single:hi_to_done", last_done_at - last_first_hi, 290);

        pix_mem[0] = 32'h00123456; pix_mem[1] = 32'h00FEDCBA; pix_mem[2] = 32'h0000FF81;
        run_frame("t2_b2b", 24, 3, 3, 1, 10, 7, 3, 20, -1, 0, 0, 72, 0, 3);

        pix_mem[0] = 32'h00800001; pix_mem[1] = 32'h007FFFFE;
        run_frame("t3_underrun", 24, 4, 2, 0, 10, 7, 3, 30, -1, 0, 0, 48, 1, 2);

        pix_mem[0] = 32'h00C3A5F0;
        run_frame("t4_period1", 24, 1, 1, 0, 1, 1, 0, 3, -1, 0, 0, 24, 0, 1);

        pix_mem[0] = 32'h00F0F0F0; pix_mem[1] = 32'h000F0F0F;
        run_frame("t5_full_hi_lo", 24, 2, 2, 0, 10, 12, 0, 10, -1, 0, 0, 48, 0, 2);

        run_frame("t6_zero_leds", 24, 0, 0, 0, 10, 7, 3, 5, -1, 0, 0, 0, 0, 0);
        check_eq("t6_zero_leds:done_at", last_done_at, 5);

        pix_mem[0] = 32'h00AAAAAA; pix_mem[1] = 32'h00555555;
        run_frame("t7_en_abort", 24, 2, 2, 0, 10, 7, 3, 15, 25, 0, 0, 3, 0, 2);

        sel = 1'b1;
        pix_mem[0] = 32'hDEADBEEF; pix_mem[1] = 32'h01234567;
        run_frame("t8_rgbw", 32, 2, 2, 0, 8, 5, 2, 12, -1, 1, 0, 64, 0, 2);
        sel = 1'b0;

        pix_mem[0] = 32'h00FFFFFF;
        led_count = 10'd2; t_period = 16'd10; t_hi1 = 16'd7; t_hi0 = 16'd3; t_latch = 16'd20;
        pix_data32 = pix_mem[0]; pix_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_out) begin found = 1'b1; break; end
        end
        check_eq("t9_reset:outpin_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        check_eq("t9_reset:outpin", 32'(o_out), 32'd0);
        check_eq("t9_reset:busy", 32'(o_busy), 32'd0);
        n_done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_done || o_und || o_busy) n_done++;
        end
        check_eq("t9_reset:no_done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_strip_driver.md
Name: rgb_strip_driver

Overview:
- Parametrised successor to the single-byte RGB bit driver.
- Streams a whole frame of N pixels, each BITS_PER_LED bits, to a single-wire RGB/RGBW LED chain using per-bit PWM encoding, then appends the latch/reset low period.
- Pixel data arrives over a valid/ready stream into a one-entry holding register, so pixels are transmitted back-to-back with no gap.
- Sits between the frame-buffer reader and the LED output pin.

Parameters:
- BITS_PER_LED, 24, bits per pixel (24 RGB, 32 RGBW); sent MSB first.
- CNT_W, 16, width of all timing counters and timing inputs.
- LED_CNT_W, 10, width of the pixel-count input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enable; start is ignored while low; deassertion aborts the frame.
- start  in  1  one-cycle frame request, accepted only in IDLE.
- led_count  in  LED_CNT_W  pixels in the frame; sampled at start.
- t_period  in  CNT_W  bit period in clk cycles; sampled at start.
- t_hi1  in  CNT_W  high time for a 1 bit; sampled at start.
- t_hi0  in  CNT_W  high time for a 0 bit; sampled at start.
- t_latch  in  CNT_W  low latch time after the frame; sampled at start.
- pix_data  in  BITS_PER_LED  pixel word.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  the holding register can accept a pixel.
- busy  out  1  a frame is in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when the frame, including the latch period, completes.
- underrun  out  1  one-cycle pulse when the frame is aborted for lack of data.
- outpin  out  1  serial LED data line.

Behaviour:
- Reset
  - Synchronous; all outputs are 0 after the edge on which reset is sampled.
  - State returns to IDLE, the holding register is emptied, and all counters are cleared.
  - Reset mid-frame takes outpin low on that edge; no done or underrun pulse is generated.
- State machine: IDLE, WAIT_FIRST, SEND, LATCH.
- IDLE
  - outpin=0.
  - start&en: latch the configuration, clear the pixel and bit counters, go to WAIT_FIRST.
  - If led_count=0, go directly to LATCH instead.
- pix_ready
  - Equals (holding register empty) & busy & (pixels accepted < led_count) & state!=LATCH.
  - A transfer happens on a cycle where pix_valid&pix_ready.
- WAIT_FIRST
  - outpin=0.
  - Waits indefinitely for the holding register to fill.
  - Then moves the word into the shift register and goes to SEND; the first bit starts the next cycle.
- SEND, bit timing
  - The bit counter runs 0..P-1, where P=max(t_period,2).
  - outpin=1 while counter < H, where H=t_hi1 if the current MSB is 1, else t_hi0.
  - H>=P gives a high level for the whole period; H=0 gives a low level for the whole period.
  - outpin is registered: the level for counter value k appears on the cycle after k is loaded.
  - Each bit occupies exactly P cycles.
- SEND, at the end of each bit
  - Shift left by 1.
  - After BITS_PER_LED bits, increment the pixel count.
- SEND, end of a pixel
  - Frame finished (pixel count = led_count): go to LATCH.
  - Otherwise, holding register full: reload it into the shift register and continue with no gap cycle.
  - Otherwise, holding register empty: pulse underrun, go to LATCH.
- A holding-register fill and drain on the same cycle is legal.
  - The drain happens first, so pix_ready may stay high.
- LATCH
  - outpin=0 for max(t_latch,1) cycles.
  - Then pulse done for one cycle and go to IDLE; busy drops on the same cycle done pulses.
  - Aborted frames also pass through LATCH and pulse done.
- en deasserted while busy
  - The current bit completes.
  - Then go to LATCH, with no underrun pulse; the holding register is discarded.
- Start handling
  - start while busy is ignored.
  - start on the same cycle done pulses is ignored; it is accepted from the following cycle.
- Widths
  - All counters are CNT_W or LED_CNT_W bits and never wrap within legal input ranges.
  - Configuration changes during a frame have no effect.

Test Plan:
- Single-pixel colour frame:
  - Config: BITS_PER_LED=24, t_period=10, t_hi1=7, t_hi0=3, t_latch=50, led_count=1, pix_data=24'hA50F00.
  - Required: 24 bits of 10 cycles each, MSB first, with high widths 7,3,7,3,3,7,3,7 (0xA5), then 3,3,3,3,7,7,7,7 (0x0F), then eight 3s (0x00).
  - Then 50 low cycles and a done pulse exactly 290 cycles after the first high edge.
- Back-to-back pixels:
  - led_count=3, with pix_valid held high and three words provided.
  - Required: 72 contiguous bit periods with no extra low gap between pixels; pix_ready deasserts after the 3rd accept; done fires once.
- Underrun:
  - led_count=4, with pix_valid dropped after 2 pixels.
  - Required: the line is low after bit 48; underrun pulses at the end of pixel 2; t_latch low cycles follow, then done.
- Boundary timings:
  - t_period=1 behaves as 2.
  - t_hi1=12 with t_period=10 gives a fully high bit.
  - t_hi0=0 gives a fully low bit.
  - led_count=0 gives only the latch period, then done.
- Abort paths:
  - en dropped mid-bit in pixel 1: the bit completes, then LATCH, then done with no underrun.
  - reset asserted mid-frame: outpin=0 and busy=0 on the next edge, and no done pulse.
- RGBW variant:
  - BITS_PER_LED=32, led_count=2: 64 bit periods; start pulsed while busy is ignored (no second frame).
